// File: rtl/traffic_light_monitor_pkg.sv
// Shared colour encodings, tracker states and fault codes for the traffic light monitor.
package traffic_light_monitor_pkg;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RED    = 2'd1,
    ST_GREEN  = 2'd2,
    ST_YELLOW = 2'd3
  } trk_state_t;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_ENC      = 3'd1,
    FC_CONFLICT = 3'd2,
    FC_TRANS    = 3'd3,
    FC_G_SHORT  = 3'd4,
    FC_G_LONG   = 3'd5,
    FC_Y_WRONG  = 3'd6
  } fault_code_t;

  // ST_INIT doubles as "not a legal lamp pattern".
  function automatic trk_state_t decode_light(input logic [2:0] light);
    case (light)
      LIGHT_R: decode_light = ST_RED;
      LIGHT_Y: decode_light = ST_YELLOW;
      LIGHT_G: decode_light = ST_GREEN;
      default: decode_light = ST_INIT;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_phase_tracker.sv
// Per-direction colour tracker: decode, transition check and (with TL_MON_DURATION_EN) phase timing.
module tl_phase_tracker
  import traffic_light_monitor_pkg::*;
`ifdef TL_MON_DURATION_EN
#(
  parameter int GREEN_MIN   = 5,
  parameter int GREEN_MAX   = 30,
  parameter int YELLOW_TIME = 3,
  parameter int CNT_W       = 8
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  output logic       bad_enc,
  output logic       bad_trans,
  output logic       g_short,
  output logic       g_long,
  output logic       y_wrong,
  output logic       y_to_r
);

  trk_state_t state, state_nxt, colour;
  logic       valid, changed, legal;

  always_comb begin
    colour    = decode_light(light);
    valid     = (colour != ST_INIT);
    state_nxt = valid ? colour : state;
    changed   = valid && (state != ST_INIT) && (colour != state);
    legal     = (state == ST_RED    && colour == ST_GREEN)  ||
                (state == ST_GREEN  && colour == ST_YELLOW) ||
                (state == ST_YELLOW && colour == ST_RED);
    bad_enc   = !valid;
    bad_trans = changed && !legal;
    y_to_r    = changed && (state == ST_YELLOW) && (colour == ST_RED);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

`ifdef TL_MON_DURATION_EN
  logic [CNT_W-1:0] cnt;
  logic             timed;  // low during the baseline phase, whose length is unknown

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      timed <= 1'b0;
    end else if (valid) begin
      if (state == ST_INIT) begin
        cnt   <= CNT_W'(1);
        timed <= 1'b0;
      end else if (changed) begin
        cnt   <= CNT_W'(1);
        timed <= 1'b1;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    g_short = timed && changed && (state == ST_GREEN)  && (cnt <  CNT_W'(GREEN_MIN));
    y_wrong = timed && changed && (state == ST_YELLOW) && (cnt != CNT_W'(YELLOW_TIME));
    g_long  = timed && (state == ST_GREEN) && (colour == ST_GREEN) &&
              (cnt == CNT_W'(GREEN_MAX));
  end
`else
  always_comb begin
    g_short = 1'b0;
    g_long  = 1'b0;
    y_wrong = 1'b0;
  end
`endif

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the two-direction traffic light controller outputs.
// Phase-duration checks (codes 4/5/6) are built only when TL_MON_DURATION_EN is defined.
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
`ifdef TL_MON_DURATION_EN
  parameter int GREEN_MIN   = 5,
  parameter int GREEN_MAX   = 30,
  parameter int YELLOW_TIME = 3,
`endif
  parameter int CNT_W       = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light_A,
  input  logic [2:0]       light_B,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             fault_dir,
  output logic [CNT_W-1:0] cycle_count
);

  logic a_enc, a_trans, a_gs, a_gl, a_yw, a_y2r;
  logic b_enc, b_trans, b_gs, b_gl, b_yw, b_y2r;
  logic conflict;
  fault_code_t code_nxt, code_q;
  logic        dir_nxt, dir_q;

`ifdef TL_MON_DURATION_EN
  tl_phase_tracker #(.GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
                     .YELLOW_TIME(YELLOW_TIME), .CNT_W(CNT_W)) u_trk_a (
`else
  tl_phase_tracker u_trk_a (
`endif
    .clk(clk), .rst(rst), .light(light_A),
    .bad_enc(a_enc), .bad_trans(a_trans), .g_short(a_gs),
    .g_long(a_gl), .y_wrong(a_yw), .y_to_r(a_y2r)
  );

`ifdef TL_MON_DURATION_EN
  tl_phase_tracker #(.GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
                     .YELLOW_TIME(YELLOW_TIME), .CNT_W(CNT_W)) u_trk_b (
`else
  tl_phase_tracker u_trk_b (
`endif
    .clk(clk), .rst(rst), .light(light_B),
    .bad_enc(b_enc), .bad_trans(b_trans), .g_short(b_gs),
    .g_long(b_gl), .y_wrong(b_yw), .y_to_r(b_y2r)
  );

  // Lowest code wins; within a code, A is checked before B.
  always_comb begin
    conflict = (light_A != LIGHT_R) && (light_B != LIGHT_R);
    code_nxt = FC_NONE;
    dir_nxt  = 1'b0;
    if      (a_enc)   code_nxt = FC_ENC;
    else if (b_enc)   begin code_nxt = FC_ENC;     dir_nxt = 1'b1; end
    else if (conflict) code_nxt = FC_CONFLICT;
    else if (a_trans) code_nxt = FC_TRANS;
    else if (b_trans) begin code_nxt = FC_TRANS;   dir_nxt = 1'b1; end
    else if (a_gs)    code_nxt = FC_G_SHORT;
    else if (b_gs)    begin code_nxt = FC_G_SHORT; dir_nxt = 1'b1; end
    else if (a_gl)    code_nxt = FC_G_LONG;
    else if (b_gl)    begin code_nxt = FC_G_LONG;  dir_nxt = 1'b1; end
    else if (a_yw)    code_nxt = FC_Y_WRONG;
    else if (b_yw)    begin code_nxt = FC_Y_WRONG; dir_nxt = 1'b1; end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault       <= 1'b0;
      code_q      <= FC_NONE;
      dir_q       <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (!fault && code_nxt != FC_NONE) begin
        fault  <= 1'b1;
        code_q <= code_nxt;
        dir_q  <= dir_nxt;
      end
      if (a_y2r) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign fault_code = code_q;
  assign fault_dir  = dir_q;

  // b_y2r is part of the tracker interface but only A cycles are counted.
  logic unused_b_y2r;
  assign unused_b_y2r = b_y2r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor (default parameters).
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] light_A = R;
  logic [2:0] light_B = R;
  logic       fault;
  logic [2:0] fault_code;
  logic       fault_dir;
  logic [7:0] cycle_count;

  int n_vec = 0;
  int n_err = 0;

  traffic_light_monitor dut (
    .clk(clk), .rst(rst), .light_A(light_A), .light_B(light_B),
    .fault(fault), .fault_code(fault_code), .fault_dir(fault_dir),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [2:0] a, input logic [2:0] b);
    light_A = a;
    light_B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input logic [2:0] a, input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) tick(a, b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(R, R);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    phase(G, G, 2);
    n_vec++;
    if ({fault, fault_code, fault_dir, cycle_count} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_state: got f=%b c=%0d d=%b cc=%0d, want all 0",
               fault, fault_code, fault_dir, cycle_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_legal_cycle();
    do_reset();
    phase(G, R, 10); phase(Y, R, 3);
    tick(R, G);
    n_vec++;
    if (cycle_count !== 8'd1) begin
      n_err++; $display("FAIL legal_cc1: got %0d want 1", cycle_count);
    end
    phase(R, G, 9); phase(R, Y, 3);
    phase(G, R, 30);
    n_vec++;
    if (fault !== 1'b0) begin
      n_err++; $display("FAIL green_max_edge: fault=%b code=%0d want fault 0", fault, fault_code);
    end
    phase(Y, R, 3); phase(R, G, 5); phase(R, Y, 3);
    tick(G, R);
    n_vec++;
    if (fault !== 1'b0 || cycle_count !== 8'd2) begin
      n_err++; $display("FAIL legal_cycle2: fault=%b cc=%0d want fault 0 cc 2", fault, cycle_count);
    end
  endtask

  task automatic test_conflict();
    tick(G, G);
    n_vec++;
    if ({fault, fault_code, fault_dir} !== {1'b1, 3'd2, 1'b0}) begin
      n_err++; $display("FAIL conflict: f=%b c=%0d d=%b want 1/2/0", fault, fault_code, fault_dir);
    end
    tick(3'b011, G);
    n_vec++;
    if ({fault, fault_code, fault_dir} !== {1'b1, 3'd2, 1'b0}) begin
      n_err++; $display("FAIL sticky: f=%b c=%0d d=%b want 1/2/0", fault, fault_code, fault_dir);
    end
  endtask

  task automatic test_bad_encoding();
    do_reset();
    tick(R, G); tick(R, 3'b011);
    n_vec++;
    if ({fault, fault_code, fault_dir} !== {1'b1, 3'd1, 1'b1}) begin
      n_err++; $display("FAIL enc_b: f=%b c=%0d d=%b want 1/1/1", fault, fault_code, fault_dir);
    end
    // A held in yellow across a bad sample must still count Y->R afterwards.
    do_reset();
    tick(Y, R); tick(3'b011, R);
    n_vec++;
    if ({fault_code, fault_dir} !== {3'd1, 1'b0}) begin
      n_err++; $display("FAIL enc_a: c=%0d d=%b want 1/0", fault_code, fault_dir);
    end
    tick(R, R);
    n_vec++;
    if (cycle_count !== 8'd1) begin
      n_err++; $display("FAIL enc_keeps_state: cc=%0d want 1", cycle_count);
    end
    do_reset();
    tick(R, R); tick(3'b011, 3'b110);
    n_vec++;
    if ({fault_code, fault_dir} !== {3'd1, 1'b0}) begin
      n_err++; $display("FAIL enc_tie: c=%0d d=%b want 1/0", fault_code, fault_dir);
    end
  endtask

  task automatic test_bad_transition();
    do_reset();
    tick(R, G); tick(R, G); tick(R, R);
    n_vec++;
    if ({fault, fault_code, fault_dir} !== {1'b1, 3'd3, 1'b1}) begin
      n_err++; $display("FAIL trans_b: f=%b c=%0d d=%b want 1/3/1", fault, fault_code, fault_dir);
    end
    do_reset();
    tick(R, R); tick(Y, G);
    n_vec++;
    if ({fault_code, fault_dir} !== {3'd2, 1'b0}) begin
      n_err++; $display("FAIL prio_conflict: c=%0d d=%b want 2/0", fault_code, fault_dir);
    end
  endtask

  task automatic test_durations();
    logic       ef;
    logic [2:0] ec;
`ifdef TL_MON_DURATION_EN
    ef = 1'b1;
`else
    ef = 1'b0;
`endif
    do_reset();
    tick(R, R); phase(G, R, 5); phase(Y, R, 2); tick(R, R);
    ec = ef ? 3'd6 : 3'd0;
    n_vec++;
    if ({fault, fault_code, fault_dir} !== {ef, ec, 1'b0} || cycle_count !== 8'd1) begin
      n_err++; $display("FAIL yellow_short: f=%b c=%0d d=%b cc=%0d want %b/%0d/0 cc 1",
                        fault, fault_code, fault_dir, cycle_count, ef, ec);
    end
    do_reset();
    tick(R, R); phase(G, R, 30);
    n_vec++;
    if (fault !== 1'b0) begin
      n_err++; $display("FAIL green_30: fault=%b want 0", fault);
    end
    tick(G, R);
    ec = ef ? 3'd5 : 3'd0;
    n_vec++;
    if ({fault, fault_code, fault_dir} !== {ef, ec, 1'b0}) begin
      n_err++; $display("FAIL green_long: f=%b c=%0d d=%b want %b/%0d/0",
                        fault, fault_code, fault_dir, ef, ec);
    end
    do_reset();
    tick(R, R); phase(R, G, 4); tick(R, Y);
    ec = ef ? 3'd4 : 3'd0;
    n_vec++;
    if ({fault, fault_code, fault_dir} !== {ef, ec, ef}) begin
      n_err++; $display("FAIL green_short: f=%b c=%0d d=%b want %b/%0d/%b",
                        fault, fault_code, fault_dir, ef, ec, ef);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    tick(Y, R);
    for (int i = 0; i < 5; i++) begin
      tick(R, R); phase(G, R, 5); phase(Y, R, 3);
    end
    tick(G, G);
    n_vec++;
    if (fault !== 1'b1 || cycle_count !== 8'd5) begin
      n_err++; $display("FAIL pre_reset: fault=%b cc=%0d want 1 and 5", fault, cycle_count);
    end
    rst = 1'b1;
    tick(G, G);
    rst = 1'b0;
    n_vec++;
    if ({fault, fault_code, fault_dir, cycle_count} !== 13'd0) begin
      n_err++; $display("FAIL mid_reset: f=%b c=%0d d=%b cc=%0d want all 0",
                        fault, fault_code, fault_dir, cycle_count);
    end
    phase(G, R, 5); phase(Y, R, 3); phase(R, G, 5); phase(R, Y, 3); tick(G, R);
    n_vec++;
    if (fault !== 1'b0 || cycle_count !== 8'd1) begin
      n_err++; $display("FAIL after_reset: fault=%b code=%0d cc=%0d want 0 and 1",
                        fault, fault_code, cycle_count);
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_bad_encoding();
    test_bad_transition();
    test_durations();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
